branch_resolve_ctrl: RTL and testbench

//  Producer side of the branch-condition path: sequences a conditional branch across multi-cycle

---
 rtl/branch_resolve_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   Resolves one conditional branch over several cycles (IDLE -> CMP -> EVAL
//   -> WRITE). It produces the four signed compare flags, the 2-bit select
//   for the branch-ctrl mux, the one-cycle PC write-condition strobe and the
//   branch target (pc_plus4 + sign-extended word offset * 4).
//
// Ports
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_start               one-cycle resolve request, honoured only in IDLE
//   i_opcode, i_rsVal,    branch opcode, operands, word offset and PC+4,
//   i_rtVal, i_offset,      all captured on the accepted start
//   i_pcPlus4
//   o_busy                high in CMP/EVAL/WRITE
//   o_done, o_illegal     one-cycle completion pulse / unsupported opcode
//   o_branchCtrl          mux select: 00 zero, 01 GT, 10 LT|zero, 11 GT|LT
//   o_zeroFlag, o_gtFlag, registered signed compare flags of rs versus rt
//   o_ltOrZero, o_gtOrLt
//   o_pcWriteCond         PC write-condition strobe, WRITE state only
//   o_taken               selected flag, valid while o_done is high
//   o_target              branch target, held until the next accepted start
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [5:0]        i_opcode,
  input  logic [DATA_W-1:0] i_rsVal,
  input  logic [DATA_W-1:0] i_rtVal,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [DATA_W-1:0] i_pcPlus4,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_illegal,
  output logic [1:0]        o_branchCtrl,
  output logic              o_zeroFlag,
  output logic              o_gtFlag,
  output logic              o_ltOrZero,
  output logic              o_gtOrLt,
  output logic              o_pcWriteCond,
  output logic              o_taken,
  output logic [DATA_W-1:0] o_target
);

  typedef enum logic [1:0] {IDLE, CMP, EVAL, WRITE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [DATA_W-1:0] r_rsVal;
  logic [DATA_W-1:0] r_rtVal;
  logic [DATA_W-1:0] r_pcPlus4;
  logic [DATA_W-1:0] r_target;
  logic [OFF_W-1:0]  r_offset;
  logic [1:0]        r_selCode;
  logic [1:0]        r_branchCtrl;
  logic              r_illegal;
  logic [DATA_W:0]   r_diff;
  logic              r_zero;
  logic              r_gt;
  logic              r_ltOrZero;
  logic              r_gtOrLt;

  logic              w_accept;
  logic              w_opValid;
  logic [1:0]        w_opSel;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_offExt;
  logic [DATA_W-1:0] w_target;
  logic              w_diffZero;
  logic              w_selFlag;

  // Opcode decode into the mux select the branch will use.
  always_comb begin
    w_opValid = 1'b1;
    w_opSel   = 2'b00;
    case (i_opcode)
      6'h04:   w_opSel = 2'b00;
      6'h07:   w_opSel = 2'b01;
      6'h06:   w_opSel = 2'b10;
      6'h05:   w_opSel = 2'b11;
      default: w_opValid = 1'b0;
    endcase
  end

  assign w_accept = (r_state == IDLE) && i_start;

  // Both operands are sign-extended by one bit, so the subtraction cannot
  // overflow and the MSB of the difference is the true signed less-than.
  assign w_diff     = {r_rsVal[DATA_W-1], r_rsVal} - {r_rtVal[DATA_W-1], r_rtVal};
  assign w_diffZero = (r_diff == '0);
  assign w_offExt   = {{(DATA_W-OFF_W){r_offset[OFF_W-1]}}, r_offset};
  assign w_target   = r_pcPlus4 + (w_offExt << 2);

  // Flag picked by the current select; this mirrors the external mux.
  always_comb begin
    w_selFlag = 1'b0;
    case (r_branchCtrl)
      2'b00: w_selFlag = r_zero;
      2'b01: w_selFlag = r_gt;
      2'b10: w_selFlag = r_ltOrZero;
      2'b11: w_selFlag = r_gtOrLt;
      default: w_selFlag = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state and strobe outputs. Unsupported opcodes skip straight to
  // WRITE so they finish one cycle after the start.
  always_comb begin
    w_nextState   = r_state;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    o_illegal     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_taken       = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_nextState = w_opValid ? CMP : WRITE;
      end
      CMP:  w_nextState = EVAL;
      EVAL: w_nextState = WRITE;
      WRITE: begin
        o_done        = 1'b1;
        o_illegal     = r_illegal;
        o_pcWriteCond = ~r_illegal;
        o_taken       = ~r_illegal & w_selFlag;
        w_nextState   = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: capture on accept, subtract in CMP, publish flags, select and
  // target in EVAL. Select and flags then stay put through WRITE and IDLE so
  // the mux never glitches while the strobe is up.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rsVal      <= '0;
      r_rtVal      <= '0;
      r_pcPlus4    <= '0;
      r_offset     <= '0;
      r_selCode    <= 2'b00;
      r_illegal    <= 1'b0;
      r_diff       <= '0;
      r_branchCtrl <= 2'b00;
      r_zero       <= 1'b0;
      r_gt         <= 1'b0;
      r_ltOrZero   <= 1'b0;
      r_gtOrLt     <= 1'b0;
      r_target     <= '0;
    end else begin
      if (w_accept) begin
        r_rsVal   <= i_rsVal;
        r_rtVal   <= i_rtVal;
        r_pcPlus4 <= i_pcPlus4;
        r_offset  <= i_offset;
        r_selCode <= w_opSel;
        r_illegal <= ~w_opValid;
        if (!w_opValid) r_branchCtrl <= 2'b00;
      end
      if (r_state == CMP) r_diff <= w_diff;
      if (r_state == EVAL) begin
        r_zero       <= w_diffZero;
        r_gt         <= ~r_diff[DATA_W] & ~w_diffZero;
        r_ltOrZero   <= r_diff[DATA_W] | w_diffZero;
        r_gtOrLt     <= ~w_diffZero;
        r_branchCtrl <= r_selCode;
        r_target     <= w_target;
      end
    end
  end

  assign o_branchCtrl = r_branchCtrl;
  assign o_zeroFlag   = r_zero;
  assign o_gtFlag     = r_gt;
  assign o_ltOrZero   = r_ltOrZero;
  assign o_gtOrLt     = r_gtOrLt;
  assign o_target     = r_target;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Scoreboard bench: every accepted start pushes the result predicted by a
//   reference model of the branch rules into a queue, and an independent
//   monitor pops and compares each time the DUT raises o_done.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  typedef struct {
    bit          illegal;
    logic [1:0]  ctrl;
    bit          taken;
    logic [31:0] target;
    logic [3:0]  flags;
    int          cycle;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  i_opcode = '0;
  logic [31:0] i_rsVal = '0;
  logic [31:0] i_rtVal = '0;
  logic [15:0] i_offset = '0;
  logic [31:0] i_pcPlus4 = '0;
  logic        o_busy, o_done, o_illegal, o_zeroFlag, o_gtFlag;
  logic        o_ltOrZero, o_gtOrLt, o_pcWriteCond, o_taken;
  logic [1:0]  o_branchCtrl;
  logic [31:0] o_target;

  int   vectors = 0;
  int   miscompares = 0;
  int   cycleCnt = 0;
  exp_t sb[$];

  branch_resolve_ctrl #(.DATA_W(32), .OFF_W(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_opcode(i_opcode),
    .i_rsVal(i_rsVal), .i_rtVal(i_rtVal), .i_offset(i_offset), .i_pcPlus4(i_pcPlus4),
    .o_busy(o_busy), .o_done(o_done), .o_illegal(o_illegal), .o_branchCtrl(o_branchCtrl),
    .o_zeroFlag(o_zeroFlag), .o_gtFlag(o_gtFlag), .o_ltOrZero(o_ltOrZero),
    .o_gtOrLt(o_gtOrLt), .o_pcWriteCond(o_pcWriteCond), .o_taken(o_taken),
    .o_target(o_target)
  );

  // Free-running clock and an edge counter used to check latency.
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

  // Compare one value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit isBranch(input logic [5:0] op);
    return (op == 6'h04) || (op == 6'h05) || (op == 6'h06) || (op == 6'h07);
  endfunction

  // Reference model: the branch rules stated directly with signed compares.
  // doneEdge is the clock edge after which WRITE is reached.
  function automatic exp_t refModel(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [15:0] off,
                                    input logic [31:0] pc, input int acceptEdge);
    exp_t e;
    logic signed [31:0] offExt;
    bit eq, gt, lt;
    eq = (a == b);
    gt = ($signed(a) > $signed(b));
    lt = ($signed(a) < $signed(b));
    offExt = $signed(off);
    e.flags  = {eq, gt, lt | eq, !eq};
    e.target = pc + offExt * 4;
    e.illegal = !isBranch(op);
    e.ctrl  = 2'b00;
    e.taken = 1'b0;
    case (op)
      6'h04: begin e.ctrl = 2'b00; e.taken = eq;      end
      6'h07: begin e.ctrl = 2'b01; e.taken = gt;      end
      6'h06: begin e.ctrl = 2'b10; e.taken = lt | eq; end
      6'h05: begin e.ctrl = 2'b11; e.taken = !eq;     end
      default: ;
    endcase
    e.cycle = e.illegal ? acceptEdge : acceptEdge + 2;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports completion.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_reset) begin
      if (o_done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(o_done), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", 32'(cycleCnt), 32'(e.cycle));
          checkOutput("busy_at_done", 32'(o_busy), 32'd1);
          checkOutput("illegal", 32'(o_illegal), 32'(e.illegal));
          checkOutput("pc_write_cond", 32'(o_pcWriteCond), 32'(!e.illegal));
          checkOutput("branch_ctrl", 32'(o_branchCtrl), 32'(e.ctrl));
          checkOutput("taken", 32'(o_taken), 32'(e.taken));
          if (!e.illegal) begin
            checkOutput("target", o_target, e.target);
            checkOutput("flags", 32'({o_zeroFlag, o_gtFlag, o_ltOrZero, o_gtOrLt}),
                        32'(e.flags));
          end
        end
      end else begin
        checkOutput("pcwc_outside_write", 32'(o_pcWriteCond), 32'd0);
      end
    end
  end

  // Issue one branch from IDLE; optionally poke start again while busy with
  // different operands, which must be ignored. Returns once back in IDLE.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [15:0] off,
                               input logic [31:0] pc, input bit injectBusy);
    bit seen;
    @(negedge i_clk);
    i_start = 1'b1; i_opcode = op; i_rsVal = a; i_rtVal = b;
    i_offset = off; i_pcPlus4 = pc;
    sb.push_back(refModel(op, a, b, off, pc, cycleCnt + 1));
    @(negedge i_clk);
    if (injectBusy) begin
      i_opcode = 6'h05; i_rsVal = ~a; i_rtVal = a ^ 32'h1;
      i_offset = ~off; i_pcPlus4 = pc + 32'h40;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_done) begin seen = 1'b1; break; end
      @(negedge i_clk);
    end
    if (!seen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  // Start a branch, assert reset while it is in EVAL, and confirm it
  // vanishes without a completion pulse.
  task automatic abortInEval();
    int doneSeen;
    @(negedge i_clk);
    i_start = 1'b1; i_opcode = 6'h04; i_rsVal = 32'd9; i_rtVal = 32'd9;
    i_offset = 16'h0010; i_pcPlus4 = 32'h400;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    sb.delete();
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("abort_outputs", 32'({o_busy, o_done, o_illegal, o_pcWriteCond, o_taken,
                o_zeroFlag, o_gtFlag, o_ltOrZero, o_gtOrLt, o_branchCtrl}), 32'd0);
    checkOutput("abort_target", o_target, 32'd0);
    i_reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (o_done || o_pcWriteCond) doneSeen++;
    end
    checkOutput("no_done_after_abort", 32'(doneSeen), 32'd0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a, b, pc;
    logic [15:0] off;

    // Power-on reset state.
    repeat (2) @(negedge i_clk);
    checkOutput("reset_outputs", 32'({o_busy, o_done, o_illegal, o_pcWriteCond, o_taken,
                o_zeroFlag, o_gtFlag, o_ltOrZero, o_gtOrLt, o_branchCtrl}), 32'd0);
    checkOutput("reset_target", o_target, 32'd0);
    i_reset = 1'b0;

    // Directed cases.
    applyStimulus(6'h04, 32'd5, 32'd5, 16'h0003, 32'h100, 1'b0);
    applyStimulus(6'h07, 32'h8000_0000, 32'h7FFF_FFFF, 16'h0001, 32'h300, 1'b0);
    applyStimulus(6'h05, 32'd1, 32'd2, 16'hFFFF, 32'h200, 1'b0);
    applyStimulus(6'h06, 32'd1, 32'd2, 16'hFFFF, 32'h200, 1'b0);
    applyStimulus(6'h23, 32'd7, 32'd3, 16'h0004, 32'h500, 1'b0);
    applyStimulus(6'h04, 32'd42, 32'd42, 16'h0002, 32'h600, 1'b1);
    abortInEval();
    applyStimulus(6'h07, 32'd10, 32'hFFFF_FFF0, 16'h8000, 32'h1000, 1'b0);
    applyStimulus(6'h04, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h0001, 32'hFFFF_FFFC, 1'b0);

    // Randomized traffic with a bias toward equal and adjacent operands.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 6'h04;
        2, 3:    op = 6'h05;
        4, 5:    op = 6'h06;
        6, 7:    op = 6'h07;
        default: op = 6'($urandom_range(0, 63));
      endcase
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = a + 32'd1;
        2:       b = a - 32'd1;
        3:       b = {~a[31], a[30:0]};
        default: b = $urandom;
      endcase
      off = 16'($urandom);
      pc  = $urandom & 32'hFFFF_FFFC;
      applyStimulus(op, a, b, off, pc, isBranch(op) && ($urandom_range(0, 4) == 0));
    end

    repeat (4) @(negedge i_clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
